// File: rtl/comp_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : comp_serial_ctrl
//  Description : Bit-serial N-bit magnitude comparison sequencer. Drives one
//                shared 1-bit comparator MSB first, stops at the first
//                unequal bit and reports a registered gt/lt/eq/err result
//                together with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module comp_serial_ctrl #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic             err,
    output logic             cmp_a,
    output logic             cmp_b,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    input  logic             cmp_eq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] c_idx_top = IDX_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_gt;
    logic             r_lt;
    logic             r_eq;
    logic             r_err;
    logic             w_onehot;
    logic             w_decide;

    // Comparator flags are trusted only when exactly one of them is raised.
    assign w_onehot = ({cmp_gt, cmp_lt, cmp_eq} == 3'b100) ||
                      ({cmp_gt, cmp_lt, cmp_eq} == 3'b010) ||
                      ({cmp_gt, cmp_lt, cmp_eq} == 3'b001);

    // The current bit pair settles the comparison (fault, unequal or LSB reached).
    assign w_decide = !w_onehot || cmp_gt || cmp_lt || (r_idx == '0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_decide) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, bit index walk and result flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= c_idx_top;
            r_a   <= '0;
            r_b   <= '0;
            r_gt  <= 1'b0;
            r_lt  <= 1'b0;
            r_eq  <= 1'b0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_idx <= c_idx_top;
                        r_gt  <= 1'b0;
                        r_lt  <= 1'b0;
                        r_eq  <= 1'b0;
                        r_err <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!w_onehot) begin
                        r_err <= 1'b1;
                        r_gt  <= 1'b0;
                        r_lt  <= 1'b0;
                        r_eq  <= 1'b0;
                    end else if (cmp_gt) begin
                        r_gt <= 1'b1;
                    end else if (cmp_lt) begin
                        r_lt <= 1'b1;
                    end else if (r_idx == '0) begin
                        r_eq <= 1'b1;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready = (r_state == S_IDLE);
    assign busy  = (r_state == S_RUN);
    assign done  = (r_state == S_DONE);
    assign gt    = r_gt;
    assign lt    = r_lt;
    assign eq    = r_eq;
    assign err   = r_err;
    // Comparator inputs are quiet outside RUN.
    assign cmp_a = busy & r_a[r_idx];
    assign cmp_b = busy & r_b[r_idx];

endmodule
`default_nettype wire

// File: tb/tb_comp_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comp_serial_ctrl
//  Description : Self-checking bench for comp_serial_ctrl with a behavioural
//                1-bit comparator (fault injectable) and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_comp_serial_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             ready, busy, done, gt, lt, eq, err;
    logic             cmp_a, cmp_b, cmp_gt, cmp_lt, cmp_eq;

    logic             force_en = 1'b0;
    logic [2:0]       force_val = 3'b000;
    int               bit_no;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       res;     // {gt, lt, eq, err}
        int               cycles;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         accepted = 0;
    int         run_cnt = 0;
    logic       prev_done = 1'b0;
    logic [3:0] last_res = 4'b0000;

    comp_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .gt     (gt),
        .lt     (lt),
        .eq     (eq),
        .err    (err),
        .cmp_a  (cmp_a),
        .cmp_b  (cmp_b),
        .cmp_gt (cmp_gt),
        .cmp_lt (cmp_lt),
        .cmp_eq (cmp_eq)
    );

    always #5 clk = ~clk;

    // Shared 1-bit comparator; the third evaluated bit may be overridden.
    always_comb begin
        {cmp_gt, cmp_lt, cmp_eq} = {cmp_a & ~cmp_b, ~cmp_a & cmp_b, cmp_a == cmp_b};
        if (force_en && bit_no == 2) {cmp_gt, cmp_lt, cmp_eq} = force_val;
    end

    // Position of the bit currently under evaluation within an operation.
    always @(posedge clk or posedge rst) begin
        if (rst)       bit_no <= 0;
        else if (busy) bit_no <= bit_no + 1;
        else           bit_no <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference result for one operation, evaluated MSB first.
    function automatic exp_t model(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                                   input logic fault);
        exp_t e;
        e.a = oa;
        e.b = ob;
        e.res = 4'b0010;
        e.cycles = WIDTH;
        for (int k = 0; k < WIDTH; k++) begin
            if (fault && k == 2) begin
                e.res = 4'b0001;
                e.cycles = k + 1;
                return e;
            end
            if (oa[WIDTH-1-k] != ob[WIDTH-1-k]) begin
                e.res = oa[WIDTH-1-k] ? 4'b1000 : 4'b0100;
                e.cycles = k + 1;
                return e;
            end
        end
        return e;
    endfunction

    // Mid-cycle monitor: pushes on acceptance, pops and compares on done.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            run_cnt = 0;
            prev_done = 1'b0;
        end else begin
            if (prev_done) begin
                chk("done_single", 32'(done), 32'd0);
                chk("result_hold", 32'({gt, lt, eq, err}), 32'(last_res));
            end
            if (busy) begin
                chk("ready_in_run", 32'(ready), 32'd0);
                if (sb.size() > 0 && run_cnt < WIDTH) begin
                    chk("cmp_a_bit", 32'(cmp_a), 32'(sb[0].a[WIDTH-1-run_cnt]));
                    chk("cmp_b_bit", 32'(cmp_b), 32'(sb[0].b[WIDTH-1-run_cnt]));
                end
                run_cnt++;
            end else begin
                chk("cmp_idle", 32'({cmp_a, cmp_b}), 32'd0);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", 32'({gt, lt, eq, err}), 32'(e.res));
                    chk("run_cycles", 32'(run_cnt), 32'(e.cycles));
                    last_res = e.res;
                end
                run_cnt = 0;
            end
            prev_done = done;
            if (start && ready) begin
                sb.push_back(model(a, b, force_en));
                accepted++;
            end
        end
    end

    task automatic wait_acc(input int target);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk); #1;
            if (accepted >= target) ok = 1'b1;
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk); #1;
            if (sb.size() == 0 && ready) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                         input logic fe, input logic [2:0] fv);
        int target;
        target = accepted + 1;
        @(posedge clk); #2;
        a = oa; b = ob; force_en = fe; force_val = fv; start = 1'b1;
        wait_acc(target);
        @(posedge clk); #2;
        start = 1'b0;
        wait_idle();
        force_en = 1'b0;
    endtask

    initial begin
        int target;
        // Reset state.
        #3;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_flags", 32'({gt, lt, eq, err}), 32'd0);
        chk("rst_cmp", 32'({cmp_a, cmp_b}), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        do_op(8'hA5, 8'hA5, 1'b0, 3'b000);   // equal, full length
        do_op(8'h80, 8'h7F, 1'b0, 3'b000);   // MSB decides
        do_op(8'h3C, 8'h5C, 1'b0, 3'b000);   // mid-word lt

        // lt decided at bit 0; a stray start during RUN must be ignored.
        target = accepted + 1;
        @(posedge clk); #2;
        a = 8'h12; b = 8'h13; start = 1'b1;
        wait_acc(target);
        @(posedge clk); #2 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 a = 8'hFF; b = 8'h00; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        wait_idle();
        chk("ignored_start", 32'(accepted), 32'(target));

        // Comparator faults on the third bit.
        do_op(8'hC3, 8'hC3, 1'b1, 3'b000);
        do_op(8'hC3, 8'hC3, 1'b1, 3'b110);

        // Reset during RUN aborts without a done pulse.
        target = accepted + 1;
        @(posedge clk); #2;
        a = 8'h5A; b = 8'h5A; start = 1'b1;
        wait_acc(target);
        @(posedge clk); #2 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_flags", 32'({gt, lt, eq, err}), 32'd0);
        @(negedge clk);
        @(posedge clk); #2 rst = 1'b0;
        do_op(8'h01, 8'h00, 1'b0, 3'b000);

        // start held high across two back-to-back operations.
        target = accepted + 1;
        @(posedge clk); #2;
        a = 8'd3; b = 8'd5; start = 1'b1;
        wait_acc(target);
        @(posedge clk); #2 a = 8'd9; b = 8'd9;
        wait_acc(target + 1);
        @(posedge clk); #2 start = 1'b0;
        wait_idle();
        chk("b2b_accepts", 32'(accepted), 32'(target + 1));

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
